// File: rtl/key_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : key_event_decoder
//  Brief    : Turns debounced key press/release events into click,
//             double-click and long-press pulses, plus a busy flag.
//  Revision : 1.0  - initial release
// ============================================================================
module key_event_decoder #(
    parameter int CNT_WIDTH   = 25,
    parameter int LONG_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_down,
    input  logic key_up,
    output logic click_o,
    output logic double_click_o,
    output logic long_press_o,
    output logic busy_o
);

    // Timer range, computed in 64 bits so the bound check itself cannot overflow.
    localparam longint c_TIMER_RANGE = longint'(1) << CNT_WIDTH;

    // Reject parameter sets the timer cannot represent, at elaboration.
    generate
        if ((CNT_WIDTH < 1) || (CNT_WIDTH > 62) ||
            (LONG_CYCLES < 2) || (GAP_CYCLES < 2) ||
            (longint'(LONG_CYCLES) >= c_TIMER_RANGE) ||
            (longint'(GAP_CYCLES) >= c_TIMER_RANGE)) begin : g_param_err
            $error("key_event_decoder: illegal CNT_WIDTH/LONG_CYCLES/GAP_CYCLES");
        end
    endgenerate

    // Last timer value before each timeout fires; the pulse appears one edge later.
    localparam logic [CNT_WIDTH-1:0] c_LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_GAP_LAST  = CNT_WIDTH'(GAP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_TIMER_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                 state_q;
    logic [CNT_WIDTH-1:0]   timer_q;
    logic [CNT_WIDTH-1:0]   timer_inc_d;
    logic                   click_q;
    logic                   double_click_q;
    logic                   long_press_q;
    logic                   busy_q;
    logic                   w_down;
    logic                   w_up;

    // Simultaneous press and release is contradictory, so both are discarded.
    assign w_down = key_down & ~key_up;
    assign w_up   = key_up & ~key_down;

    // Saturating increment so the timer can never wrap back into a match.
    assign timer_inc_d = (timer_q == c_TIMER_MAX) ? timer_q : timer_q + 1'b1;

    // Gesture FSM: state, interval timer and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            click_q        <= 1'b0;
            double_click_q <= 1'b0;
            long_press_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            click_q        <= 1'b0;
            double_click_q <= 1'b0;
            long_press_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    if (w_down) begin
                        state_q <= PRESS;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                PRESS: begin
                    busy_q <= 1'b1;
                    if (w_up) begin
                        state_q <= GAP;
                        timer_q <= '0;
                    end else if (timer_q == c_LONG_LAST) begin
                        state_q      <= HOLD;
                        timer_q      <= '0;
                        long_press_q <= 1'b1;
                    end else begin
                        timer_q <= timer_inc_d;
                    end
                end
                GAP: begin
                    if (w_down) begin
                        state_q        <= HOLD;
                        timer_q        <= '0;
                        double_click_q <= 1'b1;
                        busy_q         <= 1'b1;
                    end else if (timer_q == c_GAP_LAST) begin
                        state_q <= IDLE;
                        timer_q <= '0;
                        click_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_inc_d;
                        busy_q  <= 1'b1;
                    end
                end
                HOLD: begin
                    timer_q <= '0;
                    if (w_up) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    timer_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign click_o        = click_q;
    assign double_click_o = double_click_q;
    assign long_press_o   = long_press_q;
    assign busy_o         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_key_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_event_decoder
//  Brief    : Directed-vector bench for key_event_decoder with a queue
//             scoreboard (expected events) and an independent output monitor.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_key_event_decoder;

    localparam int c_CNT_WIDTH   = 8;
    localparam int c_LONG_CYCLES = 10;
    localparam int c_GAP_CYCLES  = 6;

    localparam int c_K_CLICK = 0;
    localparam int c_K_DBL   = 1;
    localparam int c_K_LONG  = 2;
    localparam int c_K_BFALL = 3;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk;
    logic reset;
    logic key_down;
    logic key_up;
    logic click_o;
    logic double_click_o;
    logic long_press_o;
    logic busy_o;

    ev_t  exp_q[$];
    int   cyc        = 0;
    int   compared   = 0;
    int   mismatched = 0;
    logic prev_busy  = 1'b0;

    key_event_decoder #(
        .CNT_WIDTH   (c_CNT_WIDTH),
        .LONG_CYCLES (c_LONG_CYCLES),
        .GAP_CYCLES  (c_GAP_CYCLES)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .key_down       (key_down),
        .key_up         (key_up),
        .click_o        (click_o),
        .double_click_o (double_click_o),
        .long_press_o   (long_press_o),
        .busy_o         (busy_o)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: value k seen at a negedge means "after edge k".
    always @(posedge clk) cyc++;

    function automatic string kname(input int k);
        case (k)
            c_K_CLICK: return "click";
            c_K_DBL:   return "double_click";
            c_K_LONG:  return "long_press";
            default:   return "busy_fall";
        endcase
    endfunction

    // Pop the next expected event and compare it with an observed one.
    task automatic check_ev(input int k);
        ev_t e;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_event: got %s at edge %0d, required no event", kname(k), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
                mismatched++;
                $display("FAIL event_order: got %s at edge %0d, required %s at edge %0d",
                         kname(k), cyc, kname(e.kind), e.cyc);
            end
        end
    endtask

    // Monitor: every output event observed on the DUT is checked against the queue.
    always @(negedge clk) begin
        if ((int'(click_o === 1'b1) + int'(double_click_o === 1'b1) + int'(long_press_o === 1'b1)) > 1) begin
            compared++;
            mismatched++;
            $display("FAIL pulse_exclusive: click=%b dbl=%b long=%b at edge %0d, required at most one high",
                     click_o, double_click_o, long_press_o, cyc);
        end
        if (click_o === 1'b1)        check_ev(c_K_CLICK);
        if (double_click_o === 1'b1) check_ev(c_K_DBL);
        if (long_press_o === 1'b1)   check_ev(c_K_LONG);
        if (prev_busy && (busy_o !== 1'b1)) check_ev(c_K_BFALL);
        prev_busy = (busy_o === 1'b1);
    end

    task automatic push(input int k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Present inputs for one sampling edge, then return them to idle.
    task automatic drive(input logic d, input logic u);
        key_down = d;
        key_up   = u;
        @(posedge clk);
        #1;
        key_down = 1'b0;
        key_up   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    // Every expected event of a scenario must have been seen by now.
    task automatic drain(input string name);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL %s_missing: %0d events outstanding, next %s at edge %0d, required 0 outstanding",
                     name, exp_q.size(), kname(exp_q[0].kind), exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    task automatic check_all_low(input string name);
        check_bit({name, "_click"}, click_o, 1'b0);
        check_bit({name, "_dbl"},   double_click_o, 1'b0);
        check_bit({name, "_long"},  long_press_o, 1'b0);
        check_bit({name, "_busy"},  busy_o, 1'b0);
    endtask

    // Safety net: the directed sequence never waits on the DUT, but stop regardless.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        reset    = 1'b1;
        key_down = 1'b0;
        key_up   = 1'b0;
        idle(3);
        check_all_low("reset_state");
        reset = 1'b0;
        idle(2);

        // Single click: down E0, up E3 -> click and busy fall after E9.
        e0 = cyc + 1;
        push(c_K_CLICK, e0 + 9);
        push(c_K_BFALL, e0 + 9);
        drive(1'b1, 1'b0);
        idle(2);
        drive(1'b0, 1'b1);
        idle(12);
        drain("click");

        // Double click: down E0, up E3, down E6, up E8.
        e0 = cyc + 1;
        push(c_K_DBL,   e0 + 6);
        push(c_K_BFALL, e0 + 8);
        drive(1'b1, 1'b0);
        idle(2);
        drive(1'b0, 1'b1);
        idle(2);
        drive(1'b1, 1'b0);
        idle(1);
        drive(1'b0, 1'b1);
        idle(12);
        drain("double");

        // Long press: down E0, up E20.
        e0 = cyc + 1;
        push(c_K_LONG,  e0 + 10);
        push(c_K_BFALL, e0 + 20);
        drive(1'b1, 1'b0);
        idle(19);
        drive(1'b0, 1'b1);
        idle(5);
        drain("long");

        // Release on the long-timeout edge wins: click after E16.
        e0 = cyc + 1;
        push(c_K_CLICK, e0 + 16);
        push(c_K_BFALL, e0 + 16);
        drive(1'b1, 1'b0);
        idle(9);
        drive(1'b0, 1'b1);
        idle(10);
        drain("coincide");

        // Both keys high mid-press are ignored; long press still at E10, release E12.
        e0 = cyc + 1;
        push(c_K_LONG,  e0 + 10);
        push(c_K_BFALL, e0 + 12);
        drive(1'b1, 1'b0);
        idle(4);
        drive(1'b1, 1'b1);
        idle(6);
        drive(1'b0, 1'b1);
        idle(5);
        drain("both_in_press");

        // Abort by asynchronous reset between E5 and E6.
        e0 = cyc + 1;
        push(c_K_BFALL, e0 + 5);
        drive(1'b1, 1'b0);
        idle(2);
        drive(1'b0, 1'b1);
        idle(2);
        #1;
        reset = 1'b1;
        #1;
        check_all_low("async_reset");
        idle(3);
        reset = 1'b0;
        idle(12);
        drain("reset_abort");

        // Fresh sequence after reset behaves like the first click.
        e0 = cyc + 1;
        push(c_K_CLICK, e0 + 9);
        push(c_K_BFALL, e0 + 9);
        drive(1'b1, 1'b0);
        idle(2);
        drive(1'b0, 1'b1);
        idle(12);
        drain("post_reset_click");

        // Both keys high in IDLE: nothing happens.
        drive(1'b1, 1'b1);
        check_bit("both_idle_busy", busy_o, 1'b0);
        idle(10);
        check_bit("both_idle_busy_late", busy_o, 1'b0);
        drain("both_idle");

        // Release alone in IDLE is ignored.
        drive(1'b0, 1'b1);
        check_bit("up_idle_busy", busy_o, 1'b0);
        idle(8);
        drain("up_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
